// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection of one execution-unit result per cycle into a
// one-entry broadcast register. Define CDB_FIXED_PRIO_EN for static lowest-index-first priority.

package cdb_pkg;
    typedef struct packed {
        logic [0:3] cr0;
        logic       xer_so;
        logic       xer_ov;
        logic       xer_ca;
    } cond_exception_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5,
    localparam int PTR_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:NUM_UNITS-1]   i_unit_valid,
    output logic [0:NUM_UNITS-1]   o_unit_ready,
    input  logic [0:RS_ID_WIDTH-1] i_unit_rs_id    [NUM_UNITS],
    input  logic [0:4]             i_unit_reg_addr [NUM_UNITS],
    input  logic [0:31]            i_unit_result   [NUM_UNITS],
    input  cond_exception_t        i_unit_cr0_xer  [NUM_UNITS],
    output logic                   o_cdb_valid,
    input  logic                   i_cdb_ready,
    output logic [0:RS_ID_WIDTH-1] o_cdb_rs_id,
    output logic [0:4]             o_cdb_reg_addr,
    output logic [0:31]            o_cdb_value,
    output cond_exception_t        o_cdb_cr0_xer,
    output logic [PTR_W-1:0]       o_rr_ptr
);

    // Handshake: a unit result transfers on a cycle where unit_valid[i] && unit_ready[i];
    // the broadcast completes on a cycle where cdb_valid && cdb_ready. Valids never wait on readies.

    logic                   w_load;
    logic                   w_found;
    logic [PTR_W-1:0]       w_grant;
    logic [PTR_W-1:0]       w_rr_ptr;
    logic [0:RS_ID_WIDTH-1] w_sel_rs_id;
    logic [0:4]             w_sel_reg_addr;
    logic [0:31]            w_sel_result;
    cond_exception_t        w_sel_cr0_xer;

    logic                   r_cdb_valid;
    logic [0:RS_ID_WIDTH-1] r_cdb_rs_id;
    logic [0:4]             r_cdb_reg_addr;
    logic [0:31]            r_cdb_value;
    cond_exception_t        r_cdb_cr0_xer;

    assign w_load = !r_cdb_valid || i_cdb_ready;

    // Search every unit once, starting at the pointer and wrapping, keeping the first valid hit.
    always_comb begin
        int idx;
        idx            = 0;
        w_found        = 1'b0;
        w_grant        = '0;
        w_sel_rs_id    = '0;
        w_sel_reg_addr = '0;
        w_sel_result   = '0;
        w_sel_cr0_xer  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
`ifdef CDB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(w_rr_ptr) + k;
            if (idx >= NUM_UNITS) begin
                idx = idx - NUM_UNITS;
            end
`endif
            if (!w_found && i_unit_valid[idx]) begin
                w_found        = 1'b1;
                w_grant        = PTR_W'(idx);
                w_sel_rs_id    = i_unit_rs_id[idx];
                w_sel_reg_addr = i_unit_reg_addr[idx];
                w_sel_result   = i_unit_result[idx];
                w_sel_cr0_xer  = i_unit_cr0_xer[idx];
            end
        end
    end

    always_comb begin
        o_unit_ready = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            o_unit_ready[i] = !rst && w_load && w_found && (w_grant == PTR_W'(i));
        end
    end

`ifdef CDB_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_ptr_next;

    // With one unit the next value is always zero, so the pointer stays constant.
    assign w_ptr_next = (w_grant == PTR_W'(NUM_UNITS - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load && w_found) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_valid    <= 1'b0;
            r_cdb_rs_id    <= '0;
            r_cdb_reg_addr <= '0;
            r_cdb_value    <= '0;
            r_cdb_cr0_xer  <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_cdb_valid    <= 1'b1;
                r_cdb_rs_id    <= w_sel_rs_id;
                r_cdb_reg_addr <= w_sel_reg_addr;
                r_cdb_value    <= w_sel_result;
                r_cdb_cr0_xer  <= w_sel_cr0_xer;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign o_cdb_valid    = r_cdb_valid;
    assign o_cdb_rs_id    = r_cdb_rs_id;
    assign o_cdb_reg_addr = r_cdb_reg_addr;
    assign o_cdb_value    = r_cdb_value;
    assign o_cdb_cr0_xer  = r_cdb_cr0_xer;
    assign o_rr_ptr       = w_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter: per-unit result queues feed the DUT, a reference model
// predicts grants and pushes expected broadcasts, and a monitor checks every presented result.

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N     = 4;
    localparam int RSW   = 5;
    localparam int PTR_W = 2;
    localparam int W     = RSW + 5 + 32 + 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:N-1]     unit_valid;
    logic [0:N-1]     unit_ready;
    logic [0:RSW-1]   unit_rs_id    [N];
    logic [0:4]       unit_reg_addr [N];
    logic [0:31]      unit_result   [N];
    cond_exception_t  unit_cr0_xer  [N];
    logic             cdb_valid;
    logic             cdb_ready;
    logic [0:RSW-1]   cdb_rs_id;
    logic [0:4]       cdb_reg_addr;
    logic [0:31]      cdb_value;
    cond_exception_t  cdb_cr0_xer;
    logic [PTR_W-1:0] rr_ptr;

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RSW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_unit_valid   (unit_valid),
        .o_unit_ready   (unit_ready),
        .i_unit_rs_id   (unit_rs_id),
        .i_unit_reg_addr(unit_reg_addr),
        .i_unit_result  (unit_result),
        .i_unit_cr0_xer (unit_cr0_xer),
        .o_cdb_valid    (cdb_valid),
        .i_cdb_ready    (cdb_ready),
        .o_cdb_rs_id    (cdb_rs_id),
        .o_cdb_reg_addr (cdb_reg_addr),
        .o_cdb_value    (cdb_value),
        .o_cdb_cr0_xer  (cdb_cr0_xer),
        .o_rr_ptr       (rr_ptr)
    );

    // Pending results per unit, packed as {rs_id, reg_addr, value, cr0_xer}.
    logic [W-1:0] uq[N][$];
    logic [W-1:0] exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  m_ptr   = 0;
    bit  m_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_item();
        return {RSW'($urandom), 5'($urandom), 32'($urandom), 7'($urandom)};
    endfunction

    function automatic bit units_busy();
        for (int i = 0; i < N; i++) begin
            if (uq[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_units();
        for (int i = 0; i < N; i++) begin
            if (uq[i].size() > 0) begin
                unit_valid[i] = 1'b1;
                {unit_rs_id[i], unit_reg_addr[i], unit_result[i], unit_cr0_xer[i]} = uq[i][0];
            end else begin
                unit_valid[i]    = 1'b0;
                unit_rs_id[i]    = '0;
                unit_reg_addr[i] = '0;
                unit_result[i]   = '0;
                unit_cr0_xer[i]  = '0;
            end
        end
    endtask

    // One clock: drive at the falling edge, predict and check 1 time unit later, end at next falling edge.
    task automatic cycle(input bit rdy);
        bit           load;
        int           g;
        int           idx;
        logic [0:N-1] exp_rdy;
        cdb_ready = rdy;
        drive_units();
        #1;
        load    = !m_valid || rdy;
        g       = -1;
        exp_rdy = '0;
        if (load) begin
            for (int k = 0; k < N; k++) begin
`ifdef CDB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % N;
`endif
                if (g < 0 && uq[idx].size() > 0) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("unit_ready", 64'(unit_ready), 64'(exp_rdy));
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
        if (load) begin
            if (g >= 0) begin
                exp_q.push_back(uq[g].pop_front());
                m_valid = 1'b1;
`ifndef CDB_FIXED_PRIO_EN
                m_ptr = (g + 1) % N;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Reset mid-stream: any held broadcast is lost, unit queues keep their contents.
    task automatic do_reset();
        cdb_ready = 1'($urandom_range(0, 1));
        drive_units();
        rst = 1'b1;
        #1;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_unit_ready", 64'(unit_ready), 64'd0);
        check("rst_cdb_data", 64'({cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer}), 64'd0);
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: whenever a broadcast is presented it must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && cdb_valid) begin
                if (exp_q.size() == 0) begin
                    check("cdb_unexpected", 64'({cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer}), 64'd0);
                end else begin
                    check("cdb_data", 64'({cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer}), 64'(exp_q[0]));
                    if (cdb_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        cdb_ready = 1'b0;
        uq[1].push_back(rand_item());
        drive_units();
        repeat (2) @(negedge clk);
        #1;
        check("init_cdb_valid", 64'(cdb_valid), 64'd0);
        check("init_unit_ready", 64'(unit_ready), 64'd0);
        check("init_rr_ptr", 64'(rr_ptr), 64'd0);
        check("init_cdb_data", 64'({cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer}), 64'd0);
        @(negedge clk);
        uq[1].delete();
        rst = 1'b0;

        // Single result from unit 2.
        uq[2].push_back({RSW'(5), 5'd7, 32'hDEADBEEF, 7'h2A});
        repeat (3) cycle(1'b1);

        // Build traffic, then reset while a result is held.
        for (int i = 0; i < N; i++) begin
            repeat (3) uq[i].push_back(rand_item());
        end
        cycle(1'b1);
        cycle(1'b0);
        do_reset();

        // All units continuously valid, writeback always ready.
        for (int i = 0; i < N; i++) begin
            repeat (5) uq[i].push_back(rand_item());
        end
        while (units_busy()) cycle(1'b1);
        cycle(1'b1);

        // Stall with unit 1 waiting.
        repeat (3) uq[1].push_back(rand_item());
        cycle(1'b1);
        repeat (3) cycle(1'b0);
        repeat (3) cycle(1'b1);

        // Pointer wrap: grant unit 2 then offer units 0 and 3.
        uq[2].push_back(rand_item());
        cycle(1'b1);
        uq[0].push_back(rand_item());
        uq[3].push_back(rand_item());
        repeat (3) cycle(1'b1);

        // Units 0 and 2 both continuously valid.
        repeat (6) begin
            uq[0].push_back(rand_item());
            uq[2].push_back(rand_item());
        end
        repeat (8) cycle(1'b1);
        while (units_busy()) cycle(1'b1);

        // Random traffic and backpressure.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 30) uq[i].push_back(rand_item());
            end
            if (c == 400) do_reset();
            cycle($urandom_range(0, 99) < 70);
        end

        // Drain everything that is still pending.
        budget = 0;
        while ((units_busy() || exp_q.size() > 0 || m_valid) && budget < 400) begin
            cycle(1'b1);
            budget++;
        end
        check("drain_done", 64'(budget < 400), 64'd1);
        check("drain_exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
